julia_pixel_iterator: RTL and testbench
=======================================

Name: julia_pixel_iterator

Overview:
- Sequential controller that drives the single-step Julia datapath `z_calculator` (Znew = Z² + C, Q10.10 fixed point) one step per clock until the pixel terminates.
- Accepts one pixel job (z0, c, tag) on a valid/ready input, feeds the datapath each cycle, and registers its outputs back.
- Returns the final iteration count and final z on a valid/ready output.
- Sits between the pixel-coordinate generator and the colour-map/result writer in Julia_Worker.

Parameters:
- WIDTH, 20, total fixed-point width of z and c (signed).
- FRACTIONAL, 10, fractional bits. Must be 10: the datapath escape threshold 0x1000 equals 4.0 only at this value.
- INTEGRAL, 10, integral bits (WIDTH = FRACTIONAL + INTEGRAL).
- MAX_ITER, 255, iteration cap; range 1..255.
- TAG_WIDTH, 16, opaque pixel tag carried through unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  job valid.
- in_ready  out  1  block can accept a job.
- in_z_real  in  WIDTH  initial z real part, signed Q10.10.
- in_z_imag  in  WIDTH  initial z imaginary part, signed Q10.10.
- in_c_real  in  WIDTH  c real part, signed Q10.10.
- in_c_imag  in  WIDTH  c imaginary part, signed Q10.10.
- in_tag  in  TAG_WIDTH  pixel tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_iter  out  8  final iteration count.
- out_z_real  out  WIDTH  final z real part.
- out_z_imag  out  WIDTH  final z imaginary part.
- out_tag  out  TAG_WIDTH  tag of the job.
- busy  out  1  high in RUN.

Behaviour:
- Reset (n_rst low, asynchronous):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, busy=0; out_iter, out_z_real, out_z_imag and out_tag all 0.
  - Internal z, c, iter and tag registers clear to 0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch z0, c and tag, set iter=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - The datapath is driven with registered z, c and iter. Each cycle, z <= z_out and iter <= iteration_out.
  - Terminate when iteration_out == iter (escape with |z|² ≥ 4.0, or c == 0) or iteration_out == MAX_ITER.
  - On terminate, load the out_* registers from z_out, iteration_out and tag, then go to DONE.
- DONE:
  - out_valid=1. All out_* signals are held stable while out_ready=0.
  - On out_ready, go to IDLE; out_valid falls on that edge.
  - A new job cannot be accepted in the same cycle (no overlap).
- Latency, counted from the accept edge to the out_valid rising edge, is N RUN cycles:
  - N = out_iter + 1 on escape or c == 0.
  - N = MAX_ITER when the cap is hit.
  - Escape and the cap both occurring on the same step: result is MAX_ITER if iteration_out == MAX_ITER; escape stall otherwise (the datapath does not increment).
- Arithmetic:
  - All multiplication, truncation and wrap-around is the datapath's.
  - The block adds no saturation.
  - A magnitude that overflows to a negative value does not count as escape.
- clear:
  - Has priority over every transition. Next state is IDLE, out_valid=0, busy=0.
  - The out_* data registers retain their values.
  - clear with in_valid in the same cycle: the job is not accepted.
- in_valid with in_ready=0 is ignored. The producer must hold the job until accepted.

Test Plan:
- Reset mid-RUN:
  - Stimulus: assert n_rst low asynchronously between clock edges during RUN.
  - Required: outputs take their reset values immediately; in_ready=1 without a clock edge.
- c=(0,0), z0=(0x00400,0):
  - Required: out_valid after 1 cycle; out_iter=0; out_z_real=0x00400.
- z0=0, c=(0x00400,0), i.e. c=1.0:
  - Step sequence: z1=1.0 with |z|²=1; z2=2.0 with |z|²=4.0, which stalls the count.
  - Required: out_iter=1, out_z_real=0x00800, out_z_imag=0, latency 2 cycles; out_tag equals in_tag.
- z0=0, c=(-1.0 = 0xFFC00, 0):
  - z cycles between -1 and 0 and never escapes.
  - Required: out_iter=255, latency 255 cycles, out_z_real=0xFFC00.
- Back-pressure and back-to-back jobs:
  - Result held with out_ready=0 for 5 cycles: all out_* stable, in_ready=0, in_valid pulses ignored.
  - Raise out_ready, then accept the next job one cycle later.
  - Required: the second job's result is independent of the first.
- clear mid-run:
  - Stimulus: clear at RUN cycle 10 of the c=-1.0 job.
  - Required: IDLE next cycle, no out_valid; a following c=0 job returns out_iter=0 correctly.

Source files
------------

// File: rtl/julia_pixel_iterator.sv
// Iterates one Julia pixel (z <= z^2 + c, signed Q10.10) one step per clock until it escapes,
// c is zero, or the iteration cap is reached. The final count and z are returned on a
// valid/ready output.
module julia_pixel_iterator #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned FRACTIONAL = 10,
  parameter int unsigned INTEGRAL   = 10,
  parameter int unsigned MAX_ITER   = 255,
  parameter int unsigned TAG_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_z_real,
  input  logic [WIDTH-1:0]     in_z_imag,
  input  logic [WIDTH-1:0]     in_c_real,
  input  logic [WIDTH-1:0]     in_c_imag,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_iter,
  output logic [WIDTH-1:0]     out_z_real,
  output logic [WIDTH-1:0]     out_z_imag,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  if (WIDTH != FRACTIONAL + INTEGRAL || FRACTIONAL != 10 || MAX_ITER < 1 || MAX_ITER > 255)
  begin : g_param_check
    $error("julia_pixel_iterator: unsupported parameter combination");
  end

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 4.0 in Q10.10 (0x1000)
  localparam logic signed [WIDTH-1:0] ESC_THRESH = WIDTH'(4 << FRACTIONAL);

  logic [1:0]                state_q, state_d;
  logic signed [WIDTH-1:0]   z_re_q, z_im_q, c_re_q, c_im_q;
  logic [7:0]                iter_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [7:0]                out_iter_q;
  logic [WIDTH-1:0]          out_z_re_q, out_z_im_q;
  logic [TAG_WIDTH-1:0]      out_tag_q;

  // Single-step datapath
  logic signed [PW-1:0]      p_rr, p_ii, p_ri;
  logic signed [WIDTH-1:0]   zn_re, zn_im;
  logic signed [PW-1:0]      m_rr, m_ii;
  logic signed [WIDTH-1:0]   mag;
  logic                      escape, c_zero, terminate, accept;
  logic [7:0]                iter_out;

  assign p_rr  = PW'(z_re_q) * PW'(z_re_q);
  assign p_ii  = PW'(z_im_q) * PW'(z_im_q);
  assign p_ri  = PW'(z_re_q) * PW'(z_im_q);

  assign zn_re = WIDTH'(p_rr >>> FRACTIONAL) - WIDTH'(p_ii >>> FRACTIONAL) + c_re_q;
  // 2*re*im: shifting one place less than FRACTIONAL doubles without widening the product
  assign zn_im = WIDTH'(p_ri >>> (FRACTIONAL - 1)) + c_im_q;

  assign m_rr  = PW'(zn_re) * PW'(zn_re);
  assign m_ii  = PW'(zn_im) * PW'(zn_im);
  assign mag   = WIDTH'(m_rr >>> FRACTIONAL) + WIDTH'(m_ii >>> FRACTIONAL);

  // A magnitude that wrapped negative fails the signed compare and is not an escape
  assign escape   = (mag >= ESC_THRESH);
  assign c_zero   = (c_re_q == '0) && (c_im_q == '0);
  assign iter_out = (escape || c_zero) ? iter_q : 8'(iter_q + 8'd1);

  assign terminate = (iter_out == iter_q) || (iter_out == 8'(MAX_ITER));
  assign accept    = (state_q == IDLE) && in_valid && !clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (terminate) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      z_re_q     <= '0;
      z_im_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      iter_q     <= '0;
      tag_q      <= '0;
      out_iter_q <= '0;
      out_z_re_q <= '0;
      out_z_im_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        z_re_q <= in_z_real;
        z_im_q <= in_z_imag;
        c_re_q <= in_c_real;
        c_im_q <= in_c_imag;
        tag_q  <= in_tag;
        iter_q <= '0;
      end else if (state_q == RUN && !clear) begin
        z_re_q <= zn_re;
        z_im_q <= zn_im;
        iter_q <= iter_out;
        if (terminate) begin
          out_iter_q <= iter_out;
          out_z_re_q <= zn_re;
          out_z_im_q <= zn_im;
          out_tag_q  <= tag_q;
        end
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign out_iter   = out_iter_q;
  assign out_z_real = out_z_re_q;
  assign out_z_imag = out_z_im_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_julia_pixel_iterator.sv
// Self-checking bench for julia_pixel_iterator: table of jobs with hand-derived results fed
// through a scoreboard queue, plus sequences for back-pressure, clear and asynchronous reset.
module tb_julia_pixel_iterator;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_z_real = '0, in_z_imag = '0, in_c_real = '0, in_c_imag = '0;
  logic [15:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_iter;
  logic [19:0] out_z_real, out_z_imag;
  logic [15:0] out_tag;
  logic        busy;

  julia_pixel_iterator dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z_real  (in_z_real),
    .in_z_imag  (in_z_imag),
    .in_c_real  (in_c_real),
    .in_c_imag  (in_c_imag),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_iter   (out_iter),
    .out_z_real (out_z_real),
    .out_z_imag (out_z_imag),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] zr, zi, cr, ci;
    logic [15:0] tag;
    logic [7:0]  iter;
    logic [19:0] ozr, ozi;
    int          lat;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_job(input vec_t v, input bit track);
    int g = 0;
    @(negedge clk);
    in_z_real = v.zr; in_z_imag = v.zi; in_c_real = v.cr; in_c_imag = v.ci; in_tag = v.tag;
    in_valid  = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) sb.push_back(v);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 600) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_within_bound", 32'(out_valid), 32'd1);
  endtask

  task automatic collect(input int lat);
    vec_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: result with no pending job at %0t", $time);
    end else begin
      e = sb.pop_front();
      check("out_iter",   32'(out_iter),   32'(e.iter));
      check("out_z_real", 32'(out_z_real), 32'(e.ozr));
      check("out_z_imag", 32'(out_z_imag), 32'(e.ozi));
      check("out_tag",    32'(out_tag),    32'(e.tag));
      check("latency",    32'(lat),        32'(e.lat));
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_busy",  32'(busy),       32'd0);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_job(v, 1'b1);
    wait_done(lat);
    collect(lat);
    release_result();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [7:0]  h_iter;
    logic [19:0] h_zr, h_zi;
    logic [15:0] h_tag;

    //            zr        zi        cr        ci        tag       iter    ozr       ozi     lat
    vecs[0] = '{20'h00400, 20'h0,    20'h0,    20'h0,    16'h1111, 8'd0,   20'h00400, 20'h0,    1};
    vecs[1] = '{20'h0,     20'h0,    20'h00400, 20'h0,   16'hBEEF, 8'd1,   20'h00800, 20'h0,    2};
    vecs[2] = '{20'h0,     20'h0,    20'hFFC00, 20'h0,   16'h2222, 8'd255, 20'hFFC00, 20'h0,    255};
    vecs[3] = '{20'h0,     20'h0,    20'h0,    20'h00400, 16'h3333, 8'd255, 20'h0,     20'hFFC00, 255};
    vecs[4] = '{20'h00800, 20'h0,    20'h0,    20'h0,    16'h4444, 8'd0,   20'h01000, 20'h0,    1};
    vecs[5] = '{20'h0,     20'h0,    20'h00800, 20'h0,   16'h5555, 8'd0,   20'h00800, 20'h0,    1};
    vecs[6] = '{20'h0,     20'h0,    20'h00200, 20'h0,   16'h6666, 8'd4,   20'h00C9D, 20'h0,    5};

    // Reset state
    #2 n_rst = 1'b0;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_iter",  32'(out_iter),  32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-pressure: result held while out_ready is low, in_valid pulses ignored
    start_job(vecs[6], 1'b1);
    wait_done(lat);
    h_iter = out_iter; h_zr = out_z_real; h_zi = out_z_imag; h_tag = out_tag;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = ~in_valid;
      in_z_real = 20'(k * 123);
      in_c_real = 20'h00100;
      in_tag    = 16'(k);
      @(posedge clk);
      #1;
      check("bp_out_valid",  32'(out_valid),  32'd1);
      check("bp_in_ready",   32'(in_ready),   32'd0);
      check("bp_out_iter",   32'(out_iter),   32'(h_iter));
      check("bp_out_z_real", 32'(out_z_real), 32'(h_zr));
      check("bp_out_z_imag", 32'(out_z_imag), 32'(h_zi));
      check("bp_out_tag",    32'(out_tag),    32'(h_tag));
    end
    @(negedge clk);
    in_valid = 1'b0;
    collect(lat);
    release_result();
    run_vec(vecs[1]);

    // clear in IDLE together with in_valid: job must not be accepted
    @(negedge clk);
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clr_idle_busy",     32'(busy),     32'd0);
    check("clr_idle_in_ready", 32'(in_ready), 32'd1);

    // clear at RUN cycle 10 of the c=-1.0 job
    start_job(vecs[2], 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("clr_pre_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_in_ready",  32'(in_ready),  32'd1);
    check("clr_busy",      32'(busy),      32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_keep_iter", 32'(out_iter),  32'd1);
    check("clr_keep_zr",   32'(out_z_real), 32'h00800);
    repeat (3) @(posedge clk);
    #1;
    check("clr_no_valid",  32'(out_valid), 32'd0);
    run_vec(vecs[0]);

    // Asynchronous reset between clock edges during RUN
    start_job(vecs[2], 1'b0);
    repeat (3) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),   32'd1);
    check("arst_busy",      32'(busy),       32'd0);
    check("arst_out_valid", 32'(out_valid),  32'd0);
    check("arst_out_zr",    32'(out_z_real), 32'd0);
    check("arst_out_tag",   32'(out_tag),    32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    run_vec(vecs[6]);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
